// File: rtl/la_spregfile_arbiter.sv
`default_nettype none
// ============================================================================
// la_spregfile_arbiter
//   Round-robin arbiter sharing one single-port register file between NR
//   requesters; tagged read responses one cycle after the transfer.
// Revision: 1.0
// ============================================================================
module la_spregfile_arbiter #(
    parameter int NR  = 2,
    parameter int DW  = 32,
    parameter int AW  = 10,
    parameter int IDW = 3
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [NR-1:0]    req_valid,
    output logic [NR-1:0]    req_ready,
    input  logic [NR-1:0]    req_we,
    input  logic [NR*DW-1:0] req_wmask,
    input  logic [NR*AW-1:0] req_addr,
    input  logic [NR*DW-1:0] req_din,
    input  logic             hold,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [DW-1:0]    rsp_data,
    output logic             mem_ce,
    output logic             mem_we,
    output logic [DW-1:0]    mem_wmask,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_din,
    input  logic [DW-1:0]    mem_dout
);

    logic [IDW-1:0] r_ptr;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;

    logic           w_found;
    logic [IDW-1:0] w_gnt;
    logic           w_xfer;
    logic [IDW-1:0] w_ptr_next;

    function automatic int wrap(input int v);
        return (v >= NR) ? v - NR : v;
    endfunction

    // Circular priority search starting at the pointer; first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NR; k++) begin
            if (!w_found && req_valid[wrap(int'(r_ptr) + k)]) begin
                w_found = 1'b1;
                w_gnt   = IDW'(wrap(int'(r_ptr) + k));
            end
        end
    end

    assign w_xfer     = w_found & ~hold;
    assign w_ptr_next = (int'(w_gnt) == NR - 1) ? '0 : w_gnt + IDW'(1);

    // Payload mux keyed on the grant index; all-zero when idle.
    always_comb begin
        req_ready = '0;
        mem_we    = 1'b0;
        mem_wmask = '0;
        mem_addr  = '0;
        mem_din   = '0;
        for (int k = 0; k < NR; k++) begin
            if (w_xfer && (w_gnt == IDW'(k))) begin
                req_ready[k] = 1'b1;
                mem_we       = req_we[k];
                mem_wmask    = req_wmask[k*DW +: DW];
                mem_addr     = req_addr[k*AW +: AW];
                mem_din      = req_din[k*DW +: DW];
            end
        end
    end

    assign mem_ce = w_xfer;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_xfer & ~mem_we;
            if (w_xfer) begin
                r_ptr <= w_ptr_next;
            end
            if (w_xfer && !mem_we) begin
                r_rsp_id <= w_gnt;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = mem_dout;

endmodule
`default_nettype wire

// File: tb/tb_la_spregfile_arbiter.sv
`default_nettype none
// ============================================================================
// tb_la_spregfile_arbiter
//   Vector table plus scoreboard for the register-file arbiter, NR=4.
// Revision: 1.0
// ============================================================================
module tb_la_spregfile_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int IDW = 3;

    logic             clk;
    logic             nreset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_we;
    logic [NR*DW-1:0] req_wmask;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_din;
    logic             hold;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [DW-1:0]    rsp_data;
    logic             mem_ce;
    logic             mem_we;
    logic [DW-1:0]    mem_wmask;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_din;
    logic [DW-1:0]    mem_dout;

    la_spregfile_arbiter #(.NR(NR), .DW(DW), .AW(AW), .IDW(IDW)) u_dut (
        .clk       (clk),
        .nreset    (nreset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wmask (req_wmask),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .hold      (hold),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_wmask (mem_wmask),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: one-cycle read latency, bit-masked writes.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_din & mem_wmask);
            else        mem_dout      <= ram[mem_addr];
        end
    end

    typedef struct {
        bit          rst;
        logic [NR-1:0] valid;
        logic [NR-1:0] we;
        logic        hold;
        int          a;
        logic [DW-1:0] d;
        logic [DW-1:0] m;
        int          g;
    } vec_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    vec_t          tbl[$];
    rsp_t          sb[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            total = 0;
    int            bad   = 0;

    function automatic vec_t mk(bit rst, logic [NR-1:0] valid, logic [NR-1:0] we, logic hh,
                                int a, logic [DW-1:0] d, logic [DW-1:0] m, int g);
        vec_t v;
        v.rst = rst; v.valid = valid; v.we = we; v.hold = hh;
        v.a = a; v.d = d; v.m = m; v.g = g;
        return v;
    endfunction

    // Each requester gets distinct write data so a wrong mux select is visible.
    function automatic logic [DW-1:0] din_of(logic [DW-1:0] d, int i);
        return d ^ (DW'(i) << 24);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_rsp();
        rsp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_id",    64'(rsp_id),    64'(e.id));
            chk("rsp_data",  64'(rsp_data),  64'(e.data));
        end else begin
            chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        end
    endtask

    task automatic do_reset();
        req_valid = '0; req_we = '0; hold = 1'b0;
        req_addr = '0; req_din = '0; req_wmask = '0;
        nreset = 1'b0;
        sb.delete();
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id",    64'(rsp_id),    64'd0);
        chk("rst_ready",     64'(req_ready), 64'd0);
        chk("rst_mem_ce",    64'(mem_ce),    64'd0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic apply(input vec_t v);
        int            g;
        int            adr;
        logic [DW-1:0] wd;
        rsp_t          r;
        g = v.g;
        req_valid = v.valid; req_we = v.we; hold = v.hold;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = AW'(v.a + i);
            req_din[i*DW +: DW]   = din_of(v.d, i);
            req_wmask[i*DW +: DW] = v.m;
        end
        @(negedge clk);
        check_rsp();
        chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        chk("mem_ce",    64'(mem_ce),    (g < 0) ? 64'd0 : 64'd1);
        if (g >= 0) begin
            adr = v.a + g;
            wd  = din_of(v.d, g);
            chk("mem_addr", 64'(mem_addr), 64'(adr));
            chk("mem_we",   64'(mem_we),   64'(v.we[g]));
            chk("mem_din",  64'(mem_din),  64'(wd));
            chk("mem_wmask",64'(mem_wmask),64'(v.m));
            if (v.we[g]) begin
                shadow[adr] = (shadow[adr] & ~v.m) | (wd & v.m);
            end else begin
                r.id = g; r.data = shadow[adr];
                sb.push_back(r);
            end
        end else begin
            chk("mem_we_idle",    64'(mem_we),    64'd0);
            chk("mem_wmask_idle", 64'(mem_wmask), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        nreset = 1'b0; hold = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_din = '0; req_wmask = '0;

        // Single write/read, masked write, preload for contention.
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 32'h0,        32'h0,        -1));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 5, 32'hDEADBEEF, 32'hFFFFFFFF, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 5, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0,        32'h0,        -1));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 7, 32'hFFFFFFFF, 32'hFFFFFFFF, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 7, 32'h00000000, 32'h0000FFFF, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 7, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 1, 32'h11111111, 32'hFFFFFFFF, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 2, 32'h22222222, 32'hFFFFFFFF, 0));
        // Two-way contention, then hold with the pointer parked on requester 1.
        tbl.push_back(mk(1, 4'b0011, 4'b0000, 0, 1, 32'h0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 0, 1, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 0, 1, 32'h0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 1, 1, 32'h0, 32'h0, -1));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 1, 1, 32'h0, 32'h0, -1));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 0, 1, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0, 32'h0, -1));
        // Four-way fairness with writes, then a read back.
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(i == 0, 4'b1111, 4'b1111, 0, 20, 32'hA0000000 + 32'(i),
                             32'hFFFFFFFF, i % 4));
        end
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 20, 32'h0, 32'h0, 2));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0,  32'h0, 32'h0, -1));

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            apply(tbl[i]);
        end

        // Reset during a pending response: response dropped, pointer back to 0.
        apply(mk(0, 4'b0010, 4'b0000, 0, 20, 32'h0, 32'h0, 1));
        chk("pend_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("pend_rsp_id",    64'(rsp_id),    64'd1);
        nreset = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_rsp_id",    64'(rsp_id),    64'd0);
        sb.delete();
        req_valid = '0;
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;
        apply(mk(0, 4'b0101, 4'b0000, 0, 1, 32'h0, 32'h0, 0));
        apply(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0, 32'h0, -1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/la_spregfile_arbiter.md
Name: la_spregfile_arbiter

Overview:
- Round-robin arbiter that shares one single-port register file (la_spregfile) between NR independent requesters.
- Each requester has a valid/ready command channel and gets a tagged, one-cycle-latency read response.
- Drives the register file memory interface (ce/we/wmask/addr/din) and routes dout back to the granted requester.
- Sits between client blocks and the la_spregfile instance.

Parameters:
- NR, 2, number of requesters (2..8)
- DW, 32, data width; matches la_spregfile DW
- AW, 10, address width; matches la_spregfile AW
- IDW, 3, width of response id; must satisfy 2^IDW >= NR

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- req_valid  input  NR  per-requester command valid
- req_ready  output  NR  per-requester command accepted (one-hot or zero)
- req_we  input  NR  per-requester write (1) / read (0)
- req_wmask  input  NR*DW  per-requester bit write mask, requester i at [i*DW+:DW]
- req_addr  input  NR*AW  per-requester address, [i*AW+:AW]
- req_din  input  NR*DW  per-requester write data, [i*DW+:DW]
- hold  input  1  when 1, no grants are issued (maintenance/test stall)
- rsp_valid  output  1  read data valid
- rsp_id  output  IDW  index of requester owning rsp_data
- rsp_data  output  DW  read data (pass-through of mem_dout)
- mem_ce  output  1  to la_spregfile ce
- mem_we  output  1  to la_spregfile we
- mem_wmask  output  DW  to la_spregfile wmask
- mem_addr  output  AW  to la_spregfile addr
- mem_din  output  DW  to la_spregfile din
- mem_dout  input  DW  from la_spregfile dout

Behaviour:
- Reset: the asynchronous nreset=0 clears all state. Pointer ptr=0, rsp_valid=0, rsp_id=0.
- Grant (combinational within the cycle):
  - When hold=0, grant goes to the first requester with req_valid=1, searching circularly from ptr: ptr, ptr+1, ..., wrapping modulo NR.
  - req_ready is one-hot on the granted index; it is all-zero if hold=1 or no req_valid is set.
  - req_ready never depends on req_ready (no loop). It may depend on req_valid.
- Transfer: a transfer occurs when req_valid[i] and req_ready[i] are both 1 in the same cycle. At most one transfer per cycle.
- Memory drive:
  - mem_ce=1 only in a transfer cycle. mem_we, mem_wmask, mem_addr and mem_din are muxed from the granted requester.
  - With no transfer: mem_ce=0, mem_we=0, mem_wmask=0; mem_addr and mem_din are don't-care but held at 0.
- Pointer update: on the clock edge of a transfer from requester g, ptr <= (g+1) mod NR. Otherwise ptr holds.
- Read response:
  - On the edge of a read transfer (req_we=0), rsp_valid <= 1 and rsp_id <= g.
  - Otherwise rsp_valid <= 0; rsp_id holds its last value.
  - rsp_data = mem_dout combinationally. It is valid only when rsp_valid=1, i.e. exactly 1 cycle after the transfer, matching la_spregfile read latency.
  - No backpressure on responses; requesters must accept rsp when it is presented.
- Writes produce no response. The bit write follows la_spregfile wmask semantics: bit=1 writes.
- Back-to-back transfers:
  - A new transfer may occur every cycle, including a read immediately following a read.
  - rsp for transfer N appears in cycle N+1, concurrent with transfer N+1.
- Fairness: a requester holding req_valid continuously is granted within NR transfer cycles.
- Unstable inputs: requester payload may change when ready=0. Payload is sampled only in the transfer cycle.
- hold asserted mid-stream:
  - Blocks new grants immediately.
  - An already-issued read still returns rsp_valid in the next cycle.
  - ptr is unchanged while hold=1.
- Reset mid-operation: a pending response is discarded; rsp_valid=0 immediately on nreset falling.
- Single requester (only one req_valid): it is granted every cycle regardless of ptr.
- Out-of-range indices (NR < 2^IDW): rsp_id never exceeds NR-1.

Test Plan:
- Reset, then single read:
  - Write requester0 addr=5 din=0xDEADBEEF wmask=all-ones.
  - Then requester0 reads addr=5.
  - Expect rsp_valid=1 one cycle after the read transfer, rsp_id=0, rsp_data=0xDEADBEEF; no rsp after the write.
- Contention, NR=2:
  - Both requesters hold reads continuously (addr 1 and 2).
  - Expect grants alternating 0,1,0,1 starting at requester 0 after reset.
  - rsp_id sequence 0,1,0,1 with one rsp per cycle.
- Write mask:
  - Preload addr=7 with 0xFFFFFFFF, then write din=0 with wmask=0x0000FFFF.
  - Read back: expect 0xFFFF0000.
- Hold:
  - Assert hold while requester1 is valid. Expect req_ready=0 and mem_ce=0 for the whole hold.
  - Release hold: expect requester1 granted in the same cycle and ptr unchanged during the hold.
- Reset mid-response:
  - Issue a read, then pulse nreset low before the next clock edge.
  - Expect rsp_valid=0 and ptr=0.
  - After release, requester0 has priority.
- Fairness, NR=4:
  - All four requesters valid for 8 transfers.
  - Each requester is granted exactly twice, in order 0,1,2,3,0,1,2,3.
